// File: rtl/fsmc_slave_bridge_if.sv
// Signal bundle between an FSMC master / local responder and fsmc_slave_bridge.
// The slave modport is the bridge's view, the master modport the environment's view.
`timescale 1ns/1ps
interface fsmc_slave_bridge_if;
    logic        fsmc_ne;
    logic        fsmc_nwe;
    logic        fsmc_noe;
    logic [1:0]  fsmc_nbl;
    logic [25:0] fsmc_addr;
    logic [15:0] fsmc_data_i;
    logic [15:0] fsmc_data_o;
    logic [15:0] fsmc_data_t;
    logic        m_req_valid;
    logic        m_req_ready;
    logic        m_req_is_rd;
    logic [25:0] m_req_addr;
    logic [15:0] m_req_wdata;
    logic [1:0]  m_req_wmask;
    logic [15:0] s_rdata;
    logic        s_rdata_valid;
    logic        err_overrun;
    logic        err_timeout;

    modport slave (
        input  fsmc_ne, fsmc_nwe, fsmc_noe, fsmc_nbl, fsmc_addr, fsmc_data_i,
        output fsmc_data_o, fsmc_data_t,
        output m_req_valid, m_req_is_rd, m_req_addr, m_req_wdata, m_req_wmask,
        input  m_req_ready, s_rdata, s_rdata_valid,
        output err_overrun, err_timeout
    );

    modport master (
        output fsmc_ne, fsmc_nwe, fsmc_noe, fsmc_nbl, fsmc_addr, fsmc_data_i,
        input  fsmc_data_o, fsmc_data_t,
        input  m_req_valid, m_req_is_rd, m_req_addr, m_req_wdata, m_req_wmask,
        output m_req_ready, s_rdata, s_rdata_valid,
        input  err_overrun, err_timeout
    );
endinterface

// File: rtl/fsmc_slave_bridge.sv
// FSMC slave bridge: synchronises FSMC strobes and converts them to valid/ready requests.
// Optional read timeout enabled by defining FSMC_SLAVE_RD_TIMEOUT_EN.
`timescale 1ns/1ps
module fsmc_slave_bridge #(
    parameter real simulation_delay = 0.0
) (
    input  logic               clk,
    input  logic               rst_n,
    fsmc_slave_bridge_if.slave bus
);
    localparam real unused_sim_delay = simulation_delay;

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DRIVE} state_t;

    state_t      state_reg;
    logic [2:0]  ne_sync_reg, nwe_sync_reg, noe_sync_reg;  // [0]=s1 [1]=s2 [2]=s3
    logic        valid_reg, is_rd_reg, overrun_reg;
    logic [25:0] addr_reg;
    logic [15:0] wdata_reg, rdata_reg, data_t_reg;
    logic [1:0]  wmask_reg;
    logic        ne_s2, nwe_s2, nwe_s3, noe_s2, noe_s3;
    logic        wr_evt, rd_evt, window_open;
    logic        unused_ne_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ne_sync_reg  <= 3'b111;
            nwe_sync_reg <= 3'b111;
            noe_sync_reg <= 3'b111;
        end else begin
            ne_sync_reg  <= {ne_sync_reg[1:0],  bus.fsmc_ne};
            nwe_sync_reg <= {nwe_sync_reg[1:0], bus.fsmc_nwe};
            noe_sync_reg <= {noe_sync_reg[1:0], bus.fsmc_noe};
        end
    end

    assign ne_s2        = ne_sync_reg[1];
    assign unused_ne_s3 = ne_sync_reg[2];
    assign nwe_s2       = nwe_sync_reg[1];
    assign nwe_s3       = nwe_sync_reg[2];
    assign noe_s2       = noe_sync_reg[1];
    assign noe_s3       = noe_sync_reg[2];

    assign wr_evt      = ~ne_s2 & nwe_s2 & ~nwe_s3;
    assign rd_evt      = ~ne_s2 & ~noe_s2 & noe_s3;
    assign window_open = ~ne_s2 & ~noe_s2;

`ifdef FSMC_SLAVE_RD_TIMEOUT_EN
    logic [7:0] tmo_cnt_reg;
    logic       timeout_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            valid_reg   <= 1'b0;
            is_rd_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wmask_reg   <= '0;
            rdata_reg   <= '0;
            data_t_reg  <= 16'hFFFF;
            overrun_reg <= 1'b0;
`ifdef FSMC_SLAVE_RD_TIMEOUT_EN
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            data_t_reg  <= 16'hFFFF;
            overrun_reg <= (wr_evt | rd_evt) & (state_reg != IDLE);
`ifdef FSMC_SLAVE_RD_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            // The master holds addr/data/nbl stable through this sampling edge.
            if (state_reg == IDLE && (wr_evt | rd_evt)) begin
                addr_reg  <= bus.fsmc_addr;
                wdata_reg <= bus.fsmc_data_i;
                wmask_reg <= ~bus.fsmc_nbl;
            end
            case (state_reg)
                IDLE: begin
                    if (wr_evt) begin
                        state_reg <= WR_REQ;
                        valid_reg <= 1'b1;
                        is_rd_reg <= 1'b0;
                    end else if (rd_evt) begin
                        state_reg <= RD_REQ;
                        valid_reg <= 1'b1;
                        is_rd_reg <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (bus.m_req_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (bus.m_req_ready) begin
                        valid_reg <= 1'b0;
                        if (bus.s_rdata_valid) begin
                            rdata_reg  <= bus.s_rdata;
                            data_t_reg <= 16'h0000;
                            state_reg  <= RD_DRIVE;
                        end else begin
                            state_reg <= RD_WAIT;
`ifdef FSMC_SLAVE_RD_TIMEOUT_EN
                            tmo_cnt_reg <= '0;
`endif
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.s_rdata_valid) begin
                        rdata_reg <= bus.s_rdata;
                        if (window_open) begin
                            data_t_reg <= 16'h0000;
                            state_reg  <= RD_DRIVE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
`ifdef FSMC_SLAVE_RD_TIMEOUT_EN
                    else if (tmo_cnt_reg == 8'hFF) begin
                        // Responder never answered: return all-ones so the master sees a defined value.
                        rdata_reg   <= 16'hFFFF;
                        timeout_reg <= 1'b1;
                        if (window_open) begin
                            data_t_reg <= 16'h0000;
                            state_reg  <= RD_DRIVE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
`endif
                end
                RD_DRIVE: begin
                    if (window_open) begin
                        data_t_reg <= 16'h0000;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.fsmc_data_o = rdata_reg;
    assign bus.fsmc_data_t = data_t_reg;
    assign bus.m_req_valid = valid_reg;
    assign bus.m_req_is_rd = is_rd_reg;
    assign bus.m_req_addr  = addr_reg;
    assign bus.m_req_wdata = wdata_reg;
    assign bus.m_req_wmask = wmask_reg;
    assign bus.err_overrun = overrun_reg;
`ifdef FSMC_SLAVE_RD_TIMEOUT_EN
    assign bus.err_timeout = timeout_reg;
`else
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_fsmc_slave_bridge.sv
// Self-checking bench for fsmc_slave_bridge: directed FSMC cycles plus randomized reads/writes
// checked against a transaction-level scoreboard and cycle arithmetic from the bus timing rules.
`timescale 1ns/1ps
module tb_fsmc_slave_bridge;
    typedef logic [44:0] req_t;  // {is_rd, addr, wdata, wmask}

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fsmc_slave_bridge_if bus();

    fsmc_slave_bridge #(.simulation_delay(0.0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          ready_delay = 0;
    int          rdata_delay = 0;
    logic [15:0] rd_value = 16'h0000;
    req_t        exp_q[$];
    req_t        obs_q[$];
    int          ovr_cnt = 0;
    int          tmo_cnt = 0;

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Local responder: accepts after ready_delay stalled cycles, answers reads rdata_delay cycles later.
    initial begin : responder
        int stall;
        int countdown;
        stall = 0;
        countdown = -1;
        bus.m_req_ready   = 1'b0;
        bus.s_rdata       = 16'h0000;
        bus.s_rdata_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.s_rdata_valid = 1'b0;
            if (!rst_n) begin
                stall = 0;
                countdown = -1;
                bus.m_req_ready = 1'b0;
            end else begin
                if (countdown == 0) begin
                    bus.s_rdata       = rd_value;
                    bus.s_rdata_valid = 1'b1;
                    countdown = -1;
                end else if (countdown > 0) begin
                    countdown--;
                end
                if (bus.m_req_ready) begin
                    bus.m_req_ready = 1'b0;
                    stall = 0;
                end else if (bus.m_req_valid) begin
                    if (stall >= ready_delay) begin
                        bus.m_req_ready = 1'b1;
                        obs_q.push_back({bus.m_req_is_rd, bus.m_req_addr, bus.m_req_wdata, bus.m_req_wmask});
                        if (bus.m_req_is_rd && rdata_delay >= 0) countdown = rdata_delay;
                    end else begin
                        stall++;
                    end
                end else begin
                    stall = 0;
                end
            end
        end
    end

    initial begin : pulse_monitor
        forever begin
            @(posedge clk);
            #1;
            if (bus.err_overrun === 1'b1) ovr_cnt++;
            if (bus.err_timeout === 1'b1) tmo_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (bus.m_req_valid === 1'b1 && i < 60) begin
            step(1);
            i++;
        end
        check("idle_bound", 64'(bus.m_req_valid), 64'd0);
        step(2);
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_req"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
    endtask

    // nwe low 4 cycles, then high; request valid expected two edges after the first sampling edge.
    task automatic fsmc_write(input logic [25:0] a, input logic [15:0] d, input logic [1:0] nbl, input bit chk_lat);
        bus.fsmc_ne     = 1'b0;
        bus.fsmc_addr   = a;
        bus.fsmc_data_i = d;
        bus.fsmc_nbl    = nbl;
        bus.fsmc_nwe    = 1'b0;
        step(4);
        bus.fsmc_nwe = 1'b1;
        step(2);
        if (chk_lat) check("wr_valid_early", 64'(bus.m_req_valid), 64'd0);
        step(1);
        if (chk_lat) check("wr_valid_k2", 64'(bus.m_req_valid), 64'd1);
        step(1);
        bus.fsmc_ne = 1'b1;
    endtask

    // drive_at: cycle after noe falls from which the bus must be driven (0 = never driven).
    task automatic fsmc_read(input logic [25:0] a, input logic [15:0] di, input logic [1:0] nbl,
                             input int low, input int drive_at, input logic [15:0] val, input string tag);
        rd_value        = val;
        bus.fsmc_ne     = 1'b0;
        bus.fsmc_addr   = a;
        bus.fsmc_data_i = di;
        bus.fsmc_nbl    = nbl;
        bus.fsmc_noe    = 1'b0;
        for (int i = 1; i <= low + 3; i++) begin
            step(1);
            // After noe rises the drive persists through the s1 and s2 edges, released on the next.
            if (drive_at > 0 && i >= drive_at && i <= low + 2) begin
                check({tag, "_t_drive"}, 64'(bus.fsmc_data_t), 64'h0000);
                check({tag, "_data_o"}, 64'(bus.fsmc_data_o), 64'(val));
            end else begin
                check({tag, "_t_release"}, 64'(bus.fsmc_data_t), 64'hFFFF);
            end
            if (i == low) bus.fsmc_noe = 1'b1;
        end
        bus.fsmc_ne = 1'b1;
    endtask

    initial begin : main
        int          ovr0;
        int          tmo0;
        int          el;
        logic [25:0] a;
        logic [15:0] d;
        logic [15:0] v;
        logic [1:0]  nbl;
        int          low;
        int          drv;
        req_t        pay;

        rst_n           = 1'b0;
        bus.fsmc_ne     = 1'b1;
        bus.fsmc_nwe    = 1'b1;
        bus.fsmc_noe    = 1'b1;
        bus.fsmc_nbl    = 2'b11;
        bus.fsmc_addr   = '0;
        bus.fsmc_data_i = '0;
        step(3);
        check("rst_data_t", 64'(bus.fsmc_data_t), 64'hFFFF);
        check("rst_data_o", 64'(bus.fsmc_data_o), 64'h0);
        check("rst_valid",  64'(bus.m_req_valid), 64'h0);
        check("rst_is_rd",  64'(bus.m_req_is_rd), 64'h0);
        check("rst_addr",   64'(bus.m_req_addr),  64'h0);
        check("rst_wdata",  64'(bus.m_req_wdata), 64'h0);
        check("rst_wmask",  64'(bus.m_req_wmask), 64'h0);
        check("rst_ovr",    64'(bus.err_overrun), 64'h0);
        check("rst_tmo",    64'(bus.err_timeout), 64'h0);
        rst_n = 1'b1;
        step(2);

        // Basic write
        ready_delay = 0;
        exp_q.push_back({1'b0, 26'h0001234, 16'hA55A, 2'b10});
        fsmc_write(26'h0001234, 16'hA55A, 2'b01, 1'b1);
        wait_idle();
        drain_check("wr_basic");

        // Zero-wait read
        ready_delay = 0;
        rdata_delay = 0;
        exp_q.push_back({1'b1, 26'h0000ABC, 16'h0000, 2'b11});
        fsmc_read(26'h0000ABC, 16'h0000, 2'b00, 8, 5, 16'h3C3C, "rd_basic");
        wait_idle();
        drain_check("rd_basic");

        // Backpressure: five stalled cycles with stable payload, then one acceptance
        ready_delay = 5;
        pay = {1'b0, 26'h2AAAAAA, 16'h1357, 2'b11};
        exp_q.push_back(pay);
        fsmc_write(26'h2AAAAAA, 16'h1357, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 64'(bus.m_req_valid), 64'd1);
            check("bp_payload", 64'({bus.m_req_is_rd, bus.m_req_addr, bus.m_req_wdata, bus.m_req_wmask}), 64'(pay));
            step(1);
        end
        wait_idle();
        drain_check("bp");

        // Overrun: second write arrives while the first is stalled
        ready_delay = 12;
        ovr0 = ovr_cnt;
        exp_q.push_back({1'b0, 26'h0000055, 16'hBEEF, 2'b01});
        fsmc_write(26'h0000055, 16'hBEEF, 2'b10, 1'b1);
        fsmc_write(26'h00000AA, 16'hDEAD, 2'b00, 1'b0);
        wait_idle();
        check("ovr_pulses", 64'(ovr_cnt - ovr0), 64'd1);
        drain_check("ovr");

        // Read window closes before the responder answers
        ready_delay = 0;
        rdata_delay = 10;
        exp_q.push_back({1'b1, 26'h1000001, 16'h0F0F, 2'b10});
        fsmc_read(26'h1000001, 16'h0F0F, 2'b01, 6, 0, 16'h5AA5, "rd_closed");
        step(12);
        check("closed_late_data", 64'(bus.fsmc_data_o), 64'h5AA5);
        check("closed_t", 64'(bus.fsmc_data_t), 64'hFFFF);
        wait_idle();
        drain_check("rd_closed");

        // Randomized reads and writes against the scoreboard
        for (int n = 0; n < 16; n++) begin
            ready_delay = int'($urandom_range(0, 3));
            rdata_delay = int'($urandom_range(0, 3));
            a   = 26'($urandom);
            d   = 16'($urandom);
            v   = 16'($urandom);
            nbl = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                exp_q.push_back({1'b0, a, d, ~nbl});
                fsmc_write(a, d, nbl, 1'b1);
            end else begin
                drv = 5 + ready_delay + rdata_delay;
                low = drv + int'($urandom_range(0, 3));
                exp_q.push_back({1'b1, a, d, ~nbl});
                fsmc_read(a, d, nbl, low, drv, v, "rnd_rd");
            end
            wait_idle();
            drain_check("rnd");
        end

`ifdef FSMC_SLAVE_RD_TIMEOUT_EN
        // Responder never answers: all-ones driven after the timeout
        ready_delay = 0;
        rdata_delay = -1;
        tmo0 = tmo_cnt;
        exp_q.push_back({1'b1, 26'h0000777, 16'h0000, 2'b11});
        bus.fsmc_ne     = 1'b0;
        bus.fsmc_addr   = 26'h0000777;
        bus.fsmc_data_i = 16'h0000;
        bus.fsmc_nbl    = 2'b00;
        bus.fsmc_noe    = 1'b0;
        el = 0;
        while (bus.err_timeout !== 1'b1 && el < 400) begin
            step(1);
            el++;
        end
        check("tmo_seen", 64'(bus.err_timeout), 64'd1);
        check("tmo_latency_ok", 64'(el >= 255 && el <= 265), 64'd1);
        step(1);
        check("tmo_t_drive", 64'(bus.fsmc_data_t), 64'h0000);
        check("tmo_data_o", 64'(bus.fsmc_data_o), 64'hFFFF);
        bus.fsmc_noe = 1'b1;
        step(3);
        check("tmo_t_release", 64'(bus.fsmc_data_t), 64'hFFFF);
        bus.fsmc_ne = 1'b1;
        wait_idle();
        drain_check("tmo");
        check("tmo_pulses", 64'(tmo_cnt - tmo0), 64'd1);
        rdata_delay = 0;
`else
        tmo0 = tmo_cnt;
        el = 0;
        check("tmo_never", 64'(tmo0 + el), 64'd0);
`endif

        // Reset asserted while a read request is pending
        ready_delay = 30;
        bus.fsmc_ne     = 1'b0;
        bus.fsmc_addr   = 26'h3FFFFFF;
        bus.fsmc_data_i = 16'h1111;
        bus.fsmc_nbl    = 2'b00;
        bus.fsmc_noe    = 1'b0;
        el = 0;
        while (bus.m_req_valid !== 1'b1 && el < 10) begin
            step(1);
            el++;
        end
        check("rst_mid_valid", 64'(bus.m_req_valid), 64'd1);
        check("rst_mid_is_rd", 64'(bus.m_req_is_rd), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstm_valid",  64'(bus.m_req_valid), 64'h0);
        check("rstm_is_rd",  64'(bus.m_req_is_rd), 64'h0);
        check("rstm_addr",   64'(bus.m_req_addr),  64'h0);
        check("rstm_wdata",  64'(bus.m_req_wdata), 64'h0);
        check("rstm_wmask",  64'(bus.m_req_wmask), 64'h0);
        check("rstm_data_t", 64'(bus.fsmc_data_t), 64'hFFFF);
        check("rstm_data_o", 64'(bus.fsmc_data_o), 64'h0);
        check("rstm_ovr",    64'(bus.err_overrun), 64'h0);
        check("rstm_tmo",    64'(bus.err_timeout), 64'h0);
        bus.fsmc_noe = 1'b1;
        bus.fsmc_ne  = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("rstm_no_accept", 64'(obs_q.size()), 64'd0);
        obs_q.delete();

        // Recovery write after reset
        ready_delay = 0;
        exp_q.push_back({1'b0, 26'h0C0FFEE, 16'h4242, 2'b00});
        fsmc_write(26'h0C0FFEE, 16'h4242, 2'b11, 1'b1);
        wait_idle();
        drain_check("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
